// File: rtl/cq_descarte_multicanal_pkg.sv
// Shared definitions for the multi-channel CQ/discard controller:
// the per-channel state encoding and the timer width helper.
package cq_pkg;

  typedef logic [2:0] estado_t;

  localparam estado_t OCIOSO      = 3'd0;
  localparam estado_t VERIFICANDO = 3'd1;
  localparam estado_t DESCARTANDO = 3'd2;
  localparam estado_t REPROVADO   = 3'd3;
  localparam estado_t APROVADO    = 3'd4;
  localparam estado_t ERRO        = 3'd5;

  // One timer serves both the discard hold and the sensor timeout.
  function automatic int larg_timer(input int t_descarte, input int t_timeout);
    int maior;
    maior = (t_descarte > t_timeout) ? t_descarte : t_timeout;
    return $clog2(maior + 1);
  endfunction

endpackage

// File: rtl/cq_descarte_multicanal_if.sv
// Master/controller bus of the CQ stations: per-channel commands and sensor
// inputs, per-channel status outputs and the shared totals.
interface cq_descarte_multicanal_if #(
  parameter int NUM_CANAIS   = 2,
  parameter int LARGURA_CONT = 8
);
  logic [NUM_CANAIS-1:0]   cmd_verificar;
  logic [NUM_CANAIS-1:0]   sensor_cq;
  logic [NUM_CANAIS-1:0]   resultado_cq;
  logic                    limpar_contadores;
  logic [NUM_CANAIS-1:0]   descarte_ativo;
  logic [NUM_CANAIS-1:0]   garrafa_aprovada;
  logic [NUM_CANAIS-1:0]   tarefa_concluida;
  logic [NUM_CANAIS-1:0]   erro_timeout;
  logic [NUM_CANAIS-1:0]   alarme_reprovas;
  logic [LARGURA_CONT-1:0] total_aprovadas;
  logic [LARGURA_CONT-1:0] total_reprovadas;

  modport master (
    output cmd_verificar, sensor_cq, resultado_cq, limpar_contadores,
    input  descarte_ativo, garrafa_aprovada, tarefa_concluida, erro_timeout,
    input  alarme_reprovas, total_aprovadas, total_reprovadas
  );

  modport slave (
    input  cmd_verificar, sensor_cq, resultado_cq, limpar_contadores,
    output descarte_ativo, garrafa_aprovada, tarefa_concluida, erro_timeout,
    output alarme_reprovas, total_aprovadas, total_reprovadas
  );
endinterface

// File: rtl/cq_descarte_multicanal_canal.sv
// One CQ station: Moore FSM with shared hold/timeout timer, approval entry
// flag and saturating consecutive-reject streak.
module cq_canal
  import cq_pkg::*;
#(
  parameter int TEMPO_DESCARTE  = 25000000,
  parameter int TEMPO_TIMEOUT   = 100000000,
  parameter int LIMITE_REPROVAS = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_cmd,
  input  logic i_sensor,
  input  logic i_resultado,
  input  logic i_limpar,
  output logic o_descarte_ativo,
  output logic o_garrafa_aprovada,
  output logic o_tarefa_concluida,
  output logic o_erro_timeout,
  output logic o_alarme_reprovas,
  output logic o_entrada_aprovado,
  output logic o_entrada_descarte
);

  localparam int TW = larg_timer(TEMPO_DESCARTE, TEMPO_TIMEOUT);
  localparam int SW = $clog2(LIMITE_REPROVAS + 1);
  localparam logic [TW-1:0] FIM_DESCARTE = TW'(TEMPO_DESCARTE - 1);
  localparam logic [TW-1:0] FIM_TIMEOUT  = TW'(TEMPO_TIMEOUT - 1);
  localparam logic [SW-1:0] LIMITE       = SW'(LIMITE_REPROVAS);

  estado_t       r_estado;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_streak;
  logic          r_primeiro;
  estado_t       w_prox;
  logic [TW-1:0] w_timer_prox;

  assign o_entrada_aprovado = (r_estado == VERIFICANDO) && (w_prox == APROVADO);
  assign o_entrada_descarte = (r_estado == VERIFICANDO) && (w_prox == DESCARTANDO);
  assign o_alarme_reprovas  = (r_streak == LIMITE);

  // State, timer, entry flag and streak registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_estado   <= OCIOSO;
      r_timer    <= '0;
      r_primeiro <= 1'b0;
      r_streak   <= '0;
    end else begin
      r_estado   <= w_prox;
      r_timer    <= w_timer_prox;
      r_primeiro <= o_entrada_aprovado;
      if (i_limpar) begin
        r_streak <= '0;
      end else if (o_entrada_descarte && (r_streak != LIMITE)) begin
        r_streak <= r_streak + SW'(1);
      end else if (o_entrada_aprovado) begin
        r_streak <= '0;
      end else begin
        r_streak <= r_streak;
      end
    end
  end

  // Next state; the timer restarts from zero on every state change.
  always_comb begin
    w_prox       = r_estado;
    w_timer_prox = '0;
    case (r_estado)
      OCIOSO: begin
        if (i_cmd) w_prox = VERIFICANDO;
        else       w_prox = OCIOSO;
      end
      VERIFICANDO: begin
        // A bottle seen on the timeout cycle is still classified.
        if (i_sensor) begin
          w_prox = i_resultado ? APROVADO : DESCARTANDO;
        end else if (!i_cmd) begin
          w_prox = OCIOSO;
        end else if (r_timer == FIM_TIMEOUT) begin
          w_prox = ERRO;
        end else begin
          w_prox       = VERIFICANDO;
          w_timer_prox = r_timer + TW'(1);
        end
      end
      DESCARTANDO: begin
        if (r_timer == FIM_DESCARTE) begin
          w_prox = REPROVADO;
        end else begin
          w_prox       = DESCARTANDO;
          w_timer_prox = r_timer + TW'(1);
        end
      end
      REPROVADO, APROVADO, ERRO: begin
        if (!i_cmd) w_prox = OCIOSO;
        else        w_prox = r_estado;
      end
      default: begin
        w_prox       = OCIOSO;
        w_timer_prox = '0;
      end
    endcase
  end

  // Moore output decode from the state register.
  always_comb begin
    o_descarte_ativo   = 1'b0;
    o_garrafa_aprovada = 1'b0;
    o_tarefa_concluida = 1'b0;
    o_erro_timeout     = 1'b0;
    case (r_estado)
      DESCARTANDO: o_descarte_ativo = 1'b1;
      REPROVADO:   o_tarefa_concluida = 1'b1;
      APROVADO: begin
        o_tarefa_concluida = 1'b1;
        o_garrafa_aprovada = r_primeiro;
      end
      ERRO:        o_erro_timeout = 1'b1;
      default: begin
        o_descarte_ativo   = 1'b0;
        o_garrafa_aprovada = 1'b0;
        o_tarefa_concluida = 1'b0;
        o_erro_timeout     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cq_descarte_multicanal.sv
// N-channel CQ/discard controller: independent station FSMs plus shared
// saturating approve/reject totals.
module cq_descarte_multicanal #(
  parameter int NUM_CANAIS      = 2,
  parameter int TEMPO_DESCARTE  = 25000000,
  parameter int TEMPO_TIMEOUT   = 100000000,
  parameter int LIMITE_REPROVAS = 3,
  parameter int LARGURA_CONT    = 8
) (
  input logic clk,
  input logic reset_n,
  cq_descarte_multicanal_if.slave cq_if
);

  localparam int W_POP  = $clog2(NUM_CANAIS + 1);
  localparam int W_SOMA = LARGURA_CONT + W_POP;
  localparam logic [LARGURA_CONT-1:0] MAXIMO = {LARGURA_CONT{1'b1}};

  logic [NUM_CANAIS-1:0]   w_descarte, w_garrafa, w_concluida, w_erro, w_alarme;
  logic [NUM_CANAIS-1:0]   w_entra_aprov, w_entra_desc;
  logic [W_POP-1:0]        w_n_aprov, w_n_desc;
  logic [LARGURA_CONT-1:0] r_total_aprov, r_total_rej;

  function automatic logic [LARGURA_CONT-1:0] soma_sat(
    input logic [LARGURA_CONT-1:0] a,
    input logic [W_POP-1:0]        b
  );
    logic [W_SOMA-1:0] s;
    s = W_SOMA'(a) + W_SOMA'(b);
    if (s > W_SOMA'(MAXIMO)) return MAXIMO;
    else                     return s[LARGURA_CONT-1:0];
  endfunction

  for (genvar g = 0; g < NUM_CANAIS; g++) begin : g_canal
    cq_canal #(
      .TEMPO_DESCARTE (TEMPO_DESCARTE),
      .TEMPO_TIMEOUT  (TEMPO_TIMEOUT),
      .LIMITE_REPROVAS(LIMITE_REPROVAS)
    ) u_canal (
      .clk               (clk),
      .reset_n           (reset_n),
      .i_cmd             (cq_if.cmd_verificar[g]),
      .i_sensor          (cq_if.sensor_cq[g]),
      .i_resultado       (cq_if.resultado_cq[g]),
      .i_limpar          (cq_if.limpar_contadores),
      .o_descarte_ativo  (w_descarte[g]),
      .o_garrafa_aprovada(w_garrafa[g]),
      .o_tarefa_concluida(w_concluida[g]),
      .o_erro_timeout    (w_erro[g]),
      .o_alarme_reprovas (w_alarme[g]),
      .o_entrada_aprovado(w_entra_aprov[g]),
      .o_entrada_descarte(w_entra_desc[g])
    );
  end

  // Popcount of channels entering APROVADO / DESCARTANDO this cycle.
  always_comb begin
    w_n_aprov = '0;
    w_n_desc  = '0;
    for (int i = 0; i < NUM_CANAIS; i++) begin
      w_n_aprov = w_n_aprov + W_POP'(w_entra_aprov[i]);
      w_n_desc  = w_n_desc + W_POP'(w_entra_desc[i]);
    end
  end

  // Totals; a clear wins over increments arriving in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_total_aprov <= '0;
      r_total_rej   <= '0;
    end else if (cq_if.limpar_contadores) begin
      r_total_aprov <= '0;
      r_total_rej   <= '0;
    end else begin
      r_total_aprov <= soma_sat(r_total_aprov, w_n_aprov);
      r_total_rej   <= soma_sat(r_total_rej, w_n_desc);
    end
  end

  assign cq_if.descarte_ativo   = w_descarte;
  assign cq_if.garrafa_aprovada = w_garrafa;
  assign cq_if.tarefa_concluida = w_concluida;
  assign cq_if.erro_timeout     = w_erro;
  assign cq_if.alarme_reprovas  = w_alarme;
  assign cq_if.total_aprovadas  = r_total_aprov;
  assign cq_if.total_reprovadas = r_total_rej;

endmodule

// File: tb/tb_cq_descarte_multicanal.sv
// Bench for cq_descarte_multicanal: directed scenarios plus random traffic,
// every cycle compared against a phase/countdown reference model.
module tb_cq_descarte_multicanal;

  localparam int NC  = 2;
  localparam int TD  = 4;
  localparam int TT  = 10;
  localparam int LIM = 3;
  localparam int LC  = 4;
  localparam int MAXT = (1 << LC) - 1;

  typedef enum int {M_LIVRE, M_ESPERA, M_EXPULSA, M_FIM_RUIM, M_FIM_BOM, M_FALHA} fase_t;

  logic clk = 1'b0;
  logic reset_n;
  logic [NC-1:0] v_cmd, v_sen, v_res;
  logic v_limpa;

  int n_asserts = 0;
  int n_falhas  = 0;

  fase_t m_fase[NC];
  int    m_cont[NC];
  bit    m_novo[NC];
  int    m_seq[NC];
  int    m_tot_ok, m_tot_rej;

  always #5 clk = ~clk;

  cq_descarte_multicanal_if #(.NUM_CANAIS(NC), .LARGURA_CONT(LC)) cq_if ();

  assign cq_if.cmd_verificar     = v_cmd;
  assign cq_if.sensor_cq         = v_sen;
  assign cq_if.resultado_cq      = v_res;
  assign cq_if.limpar_contadores = v_limpa;

  cq_descarte_multicanal #(
    .NUM_CANAIS     (NC),
    .TEMPO_DESCARTE (TD),
    .TEMPO_TIMEOUT  (TT),
    .LIMITE_REPROVAS(LIM),
    .LARGURA_CONT   (LC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .cq_if  (cq_if)
  );

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_asserts++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, esp, $time);
    end
  endtask

  task automatic modelo_reset();
    for (int c = 0; c < NC; c++) begin
      m_fase[c] = M_LIVRE;
      m_cont[c] = 0;
      m_novo[c] = 1'b0;
      m_seq[c]  = 0;
    end
    m_tot_ok  = 0;
    m_tot_rej = 0;
  endtask

  task automatic modelo_passo();
    int n_ok, n_rej;
    n_ok  = 0;
    n_rej = 0;
    for (int c = 0; c < NC; c++) begin
      m_novo[c] = 1'b0;
      case (m_fase[c])
        M_LIVRE: if (v_cmd[c]) begin m_fase[c] = M_ESPERA; m_cont[c] = 0; end
        M_ESPERA: begin
          if (v_sen[c]) begin
            if (v_res[c]) begin
              m_fase[c] = M_FIM_BOM; m_novo[c] = 1'b1; n_ok++; m_seq[c] = 0;
            end else begin
              m_fase[c] = M_EXPULSA; m_cont[c] = TD; n_rej++;
              m_seq[c] = (m_seq[c] < LIM) ? m_seq[c] + 1 : LIM;
            end
          end else if (!v_cmd[c]) begin
            m_fase[c] = M_LIVRE;
          end else begin
            m_cont[c]++;
            if (m_cont[c] == TT) m_fase[c] = M_FALHA;
          end
        end
        M_EXPULSA: begin
          m_cont[c]--;
          if (m_cont[c] == 0) m_fase[c] = M_FIM_RUIM;
        end
        default: if (!v_cmd[c]) m_fase[c] = M_LIVRE;
      endcase
    end
    if (v_limpa) begin
      m_tot_ok = 0; m_tot_rej = 0;
      for (int c = 0; c < NC; c++) m_seq[c] = 0;
    end else begin
      m_tot_ok  = (m_tot_ok + n_ok > MAXT) ? MAXT : m_tot_ok + n_ok;
      m_tot_rej = (m_tot_rej + n_rej > MAXT) ? MAXT : m_tot_rej + n_rej;
    end
  endtask

  task automatic confere();
    logic [NC-1:0] e_d, e_g, e_t, e_e, e_a;
    for (int c = 0; c < NC; c++) begin
      e_d[c] = (m_fase[c] == M_EXPULSA);
      e_g[c] = (m_fase[c] == M_FIM_BOM) && m_novo[c];
      e_t[c] = (m_fase[c] == M_FIM_RUIM) || (m_fase[c] == M_FIM_BOM);
      e_e[c] = (m_fase[c] == M_FALHA);
      e_a[c] = (m_seq[c] == LIM);
    end
    verifica("descarte", 32'(cq_if.descarte_ativo), 32'(e_d));
    verifica("aprovada", 32'(cq_if.garrafa_aprovada), 32'(e_g));
    verifica("concluida", 32'(cq_if.tarefa_concluida), 32'(e_t));
    verifica("timeout", 32'(cq_if.erro_timeout), 32'(e_e));
    verifica("alarme", 32'(cq_if.alarme_reprovas), 32'(e_a));
    verifica("tot_aprov", 32'(cq_if.total_aprovadas), 32'(m_tot_ok));
    verifica("tot_rej", 32'(cq_if.total_reprovadas), 32'(m_tot_rej));
  endtask

  task automatic ciclo();
    @(posedge clk);
    modelo_passo();
    @(negedge clk);
    confere();
  endtask

  task automatic transacao(input int c, input bit ok);
    v_cmd[c] = 1'b1;
    ciclo();
    v_sen[c] = 1'b1;
    v_res[c] = ok;
    ciclo();
    v_sen[c] = 1'b0;
    repeat (TD + 1) ciclo();
    v_cmd[c] = 1'b0;
    repeat (2) ciclo();
  endtask

  task automatic ambos_aprovam(input bit limpa);
    v_cmd = '1;
    ciclo();
    v_sen   = '1;
    v_res   = '1;
    v_limpa = limpa;
    ciclo();
    v_sen   = '0;
    v_limpa = 1'b0;
    v_cmd   = '0;
    ciclo();
  endtask

  initial begin
    int n_d, n_t;
    reset_n = 1'b0;
    v_cmd = '0; v_sen = '0; v_res = '0; v_limpa = 1'b0;
    modelo_reset();
    repeat (2) @(negedge clk);
    verifica("rst_descarte", 32'(cq_if.descarte_ativo), 32'd0);
    verifica("rst_concluida", 32'(cq_if.tarefa_concluida), 32'd0);
    verifica("rst_tot_aprov", 32'(cq_if.total_aprovadas), 32'd0);
    verifica("rst_tot_rej", 32'(cq_if.total_reprovadas), 32'd0);
    reset_n = 1'b1;

    // 1: approval on channel 0
    v_cmd = 2'b01;
    ciclo();
    ciclo();
    v_sen = 2'b01; v_res = 2'b01;
    ciclo();
    verifica("t1_pulso", 32'(cq_if.garrafa_aprovada[0]), 32'd1);
    verifica("t1_total", 32'(cq_if.total_aprovadas), 32'd1);
    v_sen = '0;
    ciclo();
    verifica("t1_pulso_fim", 32'(cq_if.garrafa_aprovada[0]), 32'd0);
    verifica("t1_concluida", 32'(cq_if.tarefa_concluida[0]), 32'd1);
    v_cmd = '0;
    ciclo();
    verifica("t1_ocioso", 32'(cq_if.tarefa_concluida[0]), 32'd0);

    // 2: reject on channel 1, command dropped as soon as the discard starts
    v_cmd = 2'b10;
    ciclo();
    v_sen = 2'b10; v_res = 2'b00;
    ciclo();
    v_sen = '0; v_cmd = '0;
    n_d = int'(cq_if.descarte_ativo[1]);
    n_t = 0;
    for (int k = 0; k < 10; k++) begin
      ciclo();
      n_d += int'(cq_if.descarte_ativo[1]);
      n_t += int'(cq_if.tarefa_concluida[1]);
    end
    verifica("t2_largura_descarte", 32'(n_d), 32'(TD));
    verifica("t2_concluida", 32'(n_t), 32'd1);
    verifica("t2_total_rej", 32'(cq_if.total_reprovadas), 32'd1);

    // 3: sensor timeout
    v_cmd = 2'b01;
    ciclo();
    repeat (TT - 1) ciclo();
    verifica("t3_antes", 32'(cq_if.erro_timeout[0]), 32'd0);
    ciclo();
    verifica("t3_erro", 32'(cq_if.erro_timeout[0]), 32'd1);
    verifica("t3_tot_aprov", 32'(cq_if.total_aprovadas), 32'd1);
    verifica("t3_tot_rej", 32'(cq_if.total_reprovadas), 32'd1);
    v_cmd = '0;
    ciclo();
    verifica("t3_sai", 32'(cq_if.erro_timeout[0]), 32'd0);

    // 4: reject streak, cleared by approval and by limpar_contadores
    repeat (3) transacao(0, 1'b0);
    verifica("t4_alarme", 32'(cq_if.alarme_reprovas[0]), 32'd1);
    transacao(0, 1'b1);
    verifica("t4_alarme_aprov", 32'(cq_if.alarme_reprovas[0]), 32'd0);
    repeat (2) transacao(0, 1'b0);
    v_limpa = 1'b1;
    ciclo();
    v_limpa = 1'b0;
    transacao(0, 1'b0);
    verifica("t4_alarme_limpo", 32'(cq_if.alarme_reprovas[0]), 32'd0);
    verifica("t4_tot_rej", 32'(cq_if.total_reprovadas), 32'd1);

    // 5: simultaneous approvals, saturation and same-cycle clear
    v_limpa = 1'b1;
    ciclo();
    v_limpa = 1'b0;
    repeat (7) ambos_aprovam(1'b0);
    verifica("t5_catorze", 32'(cq_if.total_aprovadas), 32'd14);
    ambos_aprovam(1'b0);
    verifica("t5_satura", 32'(cq_if.total_aprovadas), 32'd15);
    ambos_aprovam(1'b1);
    verifica("t5_limpa", 32'(cq_if.total_aprovadas), 32'd0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(7) == 0) v_cmd[c] = ~v_cmd[c];
        v_sen[c] = ($urandom_range(3) == 0);
        v_res[c] = 1'($urandom_range(1));
      end
      v_limpa = ($urandom_range(63) == 0);
      ciclo();
    end

    // 6: asynchronous reset in the middle of a discard
    v_cmd = '0; v_sen = '0; v_limpa = 1'b0;
    repeat (TD + 3) ciclo();
    v_cmd = 2'b10;
    ciclo();
    v_sen = 2'b10; v_res = 2'b00;
    ciclo();
    v_sen = '0;
    ciclo();
    verifica("t6_descarte_antes", 32'(cq_if.descarte_ativo[1]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    verifica("t6_descarte_async", 32'(cq_if.descarte_ativo), 32'd0);
    verifica("t6_tot_aprov", 32'(cq_if.total_aprovadas), 32'd0);
    verifica("t6_tot_rej", 32'(cq_if.total_reprovadas), 32'd0);
    verifica("t6_alarme", 32'(cq_if.alarme_reprovas), 32'd0);
    modelo_reset();
    v_cmd = '0;
    @(negedge clk);
    reset_n = 1'b1;
    ciclo();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_falhas);
    $finish;
  end

endmodule
